// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the in-order core's pipeline controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Bit positions in the stall/flush buses for the default six-stage core
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC0_0380;

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive stalled cycles and raises a sticky timeout once the
// count reaches LIMIT.
module stall_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic timeout
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] SAT = CW'(LIMIT);

  logic [CW-1:0] wd_cnt;

  // The flag is set on the same edge that brings wd_cnt to LIMIT, so it is
  // visible in the cycle after the LIMIT-th stalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (!active) begin
        wd_cnt <= '0;
      end else if (wd_cnt != SAT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (active && (wd_cnt >= SAT - 1'b1)) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall decode, one-cycle flush/redirect FSM
// with EPC capture, and a stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int              STAGES     = 6,
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
  parameter int              WDOG_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              exc_valid,
  input  logic [PC_W-1:0]   exc_pc,
  input  logic              eret_valid,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic [PC_W-1:0]   new_pc,
  output logic              new_pc_valid,
  output logic [PC_W-1:0]   epc,
  output logic              stall_timeout,
  output logic              state_dbg
);

  // new_pc_valid is a single-cycle strobe with no ready: the PC register must
  // load new_pc in the cycle it is high; new_pc carries no meaning otherwise.

  state_e            state_q, state_d;
  logic [PC_W-1:0]   epc_q;
  logic [PC_W-1:0]   target_q;
  logic [STAGES-1:0] stall_dec;
  logic [STAGES-1:0] flush_dec;

  // Ascending scan, so the highest requesting stage is the last to write.
  always_comb begin
    stall_dec = '0;
    flush_dec = '0;
    for (int j = 0; j < STAGES; j++) begin
      if (stallreq[j]) begin
        for (int i = 0; i < STAGES; i++) begin
          stall_dec[i] = (i <= j);
          flush_dec[i] = (i == j + 1);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    stall        = stall_dec;
    flush        = flush_dec;
    new_pc_valid = 1'b0;
    case (state_q)
      RUN: begin
        if (exc_valid || eret_valid) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d      = RUN;
        stall        = '0;
        flush        = '1;
        new_pc_valid = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      epc_q    <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      // Events arriving during FLUSH belong to flushed instructions.
      if (state_q == RUN) begin
        if (exc_valid) begin
          epc_q    <= exc_pc;
          target_q <= EXC_VECTOR;
        end else if (eret_valid) begin
          target_q <= epc_q;
        end
      end
    end
  end

  assign new_pc    = target_q;
  assign epc       = epc_q;
  assign state_dbg = state_q;

  stall_watchdog #(
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .active  (|stall),
    .timeout (stall_timeout)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan sequences followed by
// random stimulus, all checked cycle by cycle against a behavioural model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int          STAGES = 6;
  localparam int          PC_W   = 32;
  localparam int          LIMIT  = 8;
  localparam logic [31:0] EXC    = DEFAULT_EXC_VECTOR;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [STAGES-1:0] stallreq;
  logic              exc_valid;
  logic [PC_W-1:0]   exc_pc;
  logic              eret_valid;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic [PC_W-1:0]   new_pc;
  logic              new_pc_valid;
  logic [PC_W-1:0]   epc;
  logic              stall_timeout;
  logic              state_dbg;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .STAGES     (STAGES),
    .PC_W       (PC_W),
    .EXC_VECTOR (EXC),
    .WDOG_LIMIT (LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq      (stallreq),
    .exc_valid     (exc_valid),
    .exc_pc        (exc_pc),
    .eret_valid    (eret_valid),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .new_pc_valid  (new_pc_valid),
    .epc           (epc),
    .stall_timeout (stall_timeout),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int              n_checks = 0;
  int              n_pass   = 0;
  logic [PC_W-1:0] exp_q[$];

  bit              m_flush;
  logic [PC_W-1:0] m_epc;
  logic [PC_W-1:0] m_target;
  int              m_run;
  bit              m_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  function automatic int top_req(input logic [STAGES-1:0] sr);
    int k = -1;
    for (int i = 0; i < STAGES; i++) if (sr[i]) k = i;
    return k;
  endfunction

  function automatic logic [STAGES-1:0] ref_stall(input logic [STAGES-1:0] sr);
    int k = top_req(sr);
    if (k < 0) return '0;
    return STAGES'((1 << (k + 1)) - 1);
  endfunction

  function automatic logic [STAGES-1:0] ref_flush(input logic [STAGES-1:0] sr);
    int k = top_req(sr);
    if (k < 0 || k + 1 >= STAGES) return '0;
    return STAGES'(1 << (k + 1));
  endfunction

  task automatic model_reset();
    m_flush  = 1'b0;
    m_epc    = '0;
    m_target = '0;
    m_run    = 0;
    m_to     = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input logic r, input logic [STAGES-1:0] sr, input logic e,
                      input logic [PC_W-1:0] pc, input logic er);
    logic [STAGES-1:0] es, ef;
    logic              ev;
    rst = r; stallreq = sr; exc_valid = e; exc_pc = pc; eret_valid = er;
    @(negedge clk);
    if (m_flush) begin
      es = '0; ef = '1; ev = 1'b1;
    end else begin
      es = ref_stall(sr); ef = ref_flush(sr); ev = 1'b0;
    end
    chk("stall", 32'(stall), 32'(es));
    chk("flush", 32'(flush), 32'(ef));
    chk("new_pc_valid", 32'(new_pc_valid), 32'(ev));
    chk("epc", epc, m_epc);
    chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
    chk("state_dbg", 32'(state_dbg), 32'(m_flush));
    if (ev) chk("new_pc", new_pc, exp_q.pop_front());
    if (r) begin
      model_reset();
    end else begin
      if (es != 0) m_run = (m_run < LIMIT) ? m_run + 1 : LIMIT;
      else m_run = 0;
      if (m_run == LIMIT) m_to = 1'b1;
      if (!m_flush && (e || er)) begin
        m_flush = 1'b1;
        if (e) begin
          m_epc    = pc;
          m_target = EXC;
        end else begin
          m_target = m_epc;
        end
        exp_q.push_back(m_target);
      end else begin
        m_flush = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic hold(input logic [STAGES-1:0] sr, input int n);
    for (int i = 0; i < n; i++) step(1'b0, sr, 1'b0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; stallreq = '0; exc_valid = 1'b0; exc_pc = '0; eret_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state
    idle(1);

    // Stall decode
    step(1'b0, 6'b000100, 1'b0, '0, 1'b0);
    chk("plan_stall_a", 32'(stall), 32'h07);
    chk("plan_flush_a", 32'(flush), 32'h08);
    step(1'b0, 6'b001001, 1'b0, '0, 1'b0);
    chk("plan_stall_b", 32'(stall), 32'h0F);
    chk("plan_flush_b", 32'(flush), 32'h10);
    step(1'b0, 6'b100000, 1'b0, '0, 1'b0);
    chk("plan_stall_top", 32'(stall), 32'h3F);
    chk("plan_flush_top", 32'(flush), 32'h00);

    // Exception, with a second exception ignored during FLUSH
    step(1'b0, '0, 1'b1, 32'h8000_0010, 1'b0);
    step(1'b0, 6'b001000, 1'b1, 32'h1234_5678, 1'b0);
    idle(2);
    chk("plan_epc", epc, 32'h8000_0010);

    // ERET returns to EPC
    step(1'b0, '0, 1'b0, '0, 1'b1);
    chk("plan_eret_pc", new_pc, 32'h8000_0010);
    idle(1);

    // Simultaneous exception and ERET
    step(1'b0, 6'b000011, 1'b1, 32'h8000_0020, 1'b1);
    idle(1);
    chk("plan_simul_epc", epc, 32'h8000_0020);

    // Back-to-back redirects
    step(1'b0, '0, 1'b1, 32'h8000_0030, 1'b0);
    idle(1);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    idle(2);

    // Reset in the FLUSH cycle cancels the pending sequence
    step(1'b0, '0, 1'b1, 32'h8000_0040, 1'b0);
    step(1'b1, '0, 1'b0, '0, 1'b0);
    idle(2);

    // Watchdog: 7 + release + 7 stays quiet, then 8 trips it
    hold(6'b000010, 7);
    idle(1);
    hold(6'b000010, 7);
    idle(1);
    chk("wd_no_timeout", 32'(stall_timeout), 32'h0);
    hold(6'b000010, 8);
    idle(2);
    chk("wd_sticky", 32'(stall_timeout), 32'h1);
    step(1'b1, '0, 1'b0, '0, 1'b0);
    idle(1);
    chk("wd_reset", 32'(stall_timeout), 32'h0);

    // Random traffic with bursty stalls
    for (int i = 0; i < 600; i++) begin
      logic [STAGES-1:0] sr;
      if ($urandom_range(0, 3) == 0) sr = '0;
      else if ($urandom_range(0, 1) == 0) sr = STAGES'(1 << $urandom_range(0, STAGES - 1));
      else sr = STAGES'($urandom);
      step(($urandom_range(0, 149) == 0), sr, ($urandom_range(0, 11) == 0), $urandom,
           ($urandom_range(0, 11) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
